// File: rtl/seg_capture.sv
// Seven-segment clock display capture: decodes multiplexed digits into hours/minutes.
// Optional SEG_CAPTURE_GLITCH_FILTER_EN accepts a sample only once it is held two cycles.
module seg_capture (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  bytee,
  input  logic [6:0]  segment,
  output logic [11:0] data_out,
  output logic        data_valid,
  output logic        frame_err
);

  typedef enum logic {COLLECT, CHECK} state_e;

  state_e state_q, state_d;
  logic [3:0][3:0] dig_q, dig_d;
  logic [3:0] inv_q, inv_d;
  logic [3:0] seen_q, seen_d;
  logic [11:0] out_q, out_d;
  logic vld_q, vld_d;
  logic err_q, err_d;

  logic onehot, take, bad, ok;
  logic [3:0] dec;
  logic [6:0] mins, hrs;

  assign onehot = $onehot(bytee);

`ifdef SEG_CAPTURE_GLITCH_FILTER_EN
  logic [10:0] prev_q;
  logic taken_q, taken_d, match;

  // taken_q stops a long-held sample being accepted more than once
  assign match   = ({bytee, segment} == prev_q);
  assign take    = onehot && match && !taken_q;
  assign taken_d = match && (taken_q || take);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q  <= '0;
      taken_q <= 1'b0;
    end else begin
      prev_q  <= {bytee, segment};
      taken_q <= taken_d;
    end
  end
`else
  assign take = onehot;
`endif

  always_comb begin
    dec = 4'd0;
    bad = 1'b0;
    unique case (segment)
      7'h3F: dec = 4'd0;
      7'h06: dec = 4'd1;
      7'h5B: dec = 4'd2;
      7'h4F: dec = 4'd3;
      7'h66: dec = 4'd4;
      7'h6D: dec = 4'd5;
      7'h7D: dec = 4'd6;
      7'h07: dec = 4'd7;
      7'h7F: dec = 4'd8;
      7'h6F: dec = 4'd9;
      default: bad = 1'b1;
    endcase
  end

  // 7 bits so an invalid tens digit cannot wrap into range
  assign mins = 7'(dig_q[1]) * 7'd10 + 7'(dig_q[0]);
  assign hrs  = 7'(dig_q[3]) * 7'd10 + 7'(dig_q[2]);
  assign ok   = ~|inv_q && (mins <= 7'd59) && (hrs <= 7'd23);

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    inv_d   = inv_q;
    seen_d  = seen_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (&seen_q) state_d = CHECK;
      end
      CHECK: begin
        state_d = COLLECT;
        seen_d  = '0;
        inv_d   = '0;
        if (ok) begin
          out_d = {hrs[5:0], mins[5:0]};
          vld_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
    if (take) begin
      for (int i = 0; i < 4; i++) begin
        if (bytee[i]) begin
          dig_d[i]  = dec;
          inv_d[i]  = bad;
          seen_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= COLLECT;
      dig_q   <= '0;
      inv_q   <= '0;
      seen_q  <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      inv_q   <= inv_d;
      seen_q  <= seen_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign data_out   = out_q;
  assign data_valid = vld_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture.
// Build with or without SEG_CAPTURE_GLITCH_FILTER_EN to match the RTL.
module tb_seg_capture;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  bytee = '0;
  logic [6:0]  segment = '0;
  logic [11:0] data_out;
  logic        data_valid;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int nv = 0;
  int ne = 0;
  int both = 0;
  int lat;

`ifdef SEG_CAPTURE_GLITCH_FILTER_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  seg_capture dut (
    .clock      (clock),
    .reset      (reset),
    .bytee      (bytee),
    .segment    (segment),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (data_valid) nv++;
    if (frame_err) ne++;
    if (data_valid && frame_err) both++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] b,
                       input logic [6:0] s,
                       input int n);
    bytee = b;
    segment = s;
    repeat (n) @(posedge clock);
    #1;
  endtask

  // mode 0 plain, 1 multi-hot/blank noise, 2 one-cycle hr-tens glitch
  task automatic frame(input logic [6:0] ht, input logic [6:0] ho,
                       input logic [6:0] mt, input logic [6:0] mo,
                       input int mode, output int l);
    nv = 0;
    ne = 0;
    drive(4'b1000, ht, 2);
    if (mode == 2) drive(4'b1000, 7'h7F, 1);
    if (mode == 1) begin
      drive(4'b0011, 7'h7F, 2);
      drive(4'b0000, 7'h6F, 1);
    end
    drive(4'b0100, ho, 2);
    if (mode == 1) drive(4'b0000, 7'h3F, 2);
    drive(4'b0010, mt, 2);
    if (mode == 1) drive(4'b1100, 7'h06, 1);
    drive(4'b0001, mo, 2);
    bytee = '0;
    segment = '0;
    l = 99;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (data_valid || frame_err) begin
        l = i;
        break;
      end
    end
    repeat (4) @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_dout", data_out, 0);
    check("rst_vld", data_valid, 0);
    check("rst_err", frame_err, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;

    frame(7'h06, 7'h5B, 7'h06, 7'h4F, 0, lat);
    check("t1213_dout", data_out, 12'h30D);
    check("t1213_nv", nv, 1);
    check("t1213_ne", ne, 0);
    check("t1213_lat", lat, LAT);

    frame(7'h06, 7'h5B, 7'h7D, 7'h4F, 0, lat);
    check("min63_dout", data_out, 12'h30D);
    check("min63_nv", nv, 0);
    check("min63_ne", ne, 1);
    check("min63_lat", lat, LAT);

    frame(7'h06, 7'h00, 7'h06, 7'h4F, 0, lat);
    check("bad00_dout", data_out, 12'h30D);
    check("bad00_nv", nv, 0);
    check("bad00_ne", ne, 1);

    frame(7'h5B, 7'h4F, 7'h6D, 7'h6F, 0, lat);
    check("t2359_dout", data_out, 12'h5FB);
    check("t2359_nv", nv, 1);
    check("t2359_ne", ne, 0);
    check("t2359_lat", lat, LAT);

    frame(7'h5B, 7'h66, 7'h3F, 7'h3F, 0, lat);
    check("h24_dout", data_out, 12'h5FB);
    check("h24_nv", nv, 0);
    check("h24_ne", ne, 1);

    frame(7'h06, 7'h5B, 7'h06, 7'h4F, 1, lat);
    check("noise_dout", data_out, 12'h30D);
    check("noise_nv", nv, 1);
    check("noise_ne", ne, 0);
    check("noise_lat", lat, LAT);

    nv = 0;
    ne = 0;
    drive(4'b1000, 7'h06, 2);
    frame(7'h5B, 7'h5B, 7'h06, 7'h4F, 0, lat);
    check("ovr_dout", data_out, 12'h58D);
    check("ovr_nv", nv, 1);
    check("ovr_ne", ne, 0);

    drive(4'b1000, 7'h06, 2);
    drive(4'b0100, 7'h5B, 2);
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_dout", data_out, 0);
    check("mid_rst_vld", data_valid, 0);
    bytee = '0;
    segment = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    nv = 0;
    ne = 0;
    repeat (4) @(posedge clock);
    #1;
    check("post_rst_nv", nv, 0);
    check("post_rst_ne", ne, 0);
    frame(7'h3F, 7'h6D, 7'h3F, 7'h07, 0, lat);
    check("t0507_dout", data_out, 12'h147);
    check("t0507_nv", nv, 1);
    check("t0507_ne", ne, 0);

    frame(7'h06, 7'h5B, 7'h06, 7'h4F, 2, lat);
`ifdef SEG_CAPTURE_GLITCH_FILTER_EN
    check("glitch_dout", data_out, 12'h30D);
    check("glitch_nv", nv, 1);
    check("glitch_ne", ne, 0);
`else
    check("glitch_dout", data_out, 12'h147);
    check("glitch_nv", nv, 0);
    check("glitch_ne", ne, 1);
`endif
    check("glitch_lat", lat, LAT);

    check("never_both", both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
